tristate_bus_arbiter: RTL and testbench

Round-robin arbiter owning a shared WIDTH-bit tri-state bus for N requesting channels. Exactly one channel's data drives the bus through a gated tri-state output; otherwise the bus is high-impedance (z). Forced z turnaround cycles separate successive owners so two drivers never overlap. Bursts are bounded per grant. Sits between N local producers and a board-level or shared on-chip tri-state bus.

---
 rtl/tristate_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one channel drives at a time,
// with forced high-impedance turnaround cycles between successive owners.
module tristate_bus_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N           = 4,
  parameter int MAX_BURST   = 4,
  parameter int TURN_CYCLES = 1,
  localparam int OW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic [N-1:0]         gnt,
  output logic [OW-1:0]        owner,
  output logic [WIDTH-1:0]     bus,
  output logic                 bus_oe,
  output logic                 xfer
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
  localparam logic [OW-1:0] LAST_RST   = OW'(N - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t            state_q;
  logic [N-1:0]      gnt_q;
  logic [OW-1:0]     owner_q;
  logic [OW-1:0]     last_q;
  logic [BW-1:0]     burst_cnt_q;
  logic [TW-1:0]     turn_cnt_q;

  logic [WIDTH-1:0]  ch_data [N];
  logic              win_vld_d;
  logic [OW-1:0]     win_idx_d;
  logic              arb_ok_d;
  logic              drive_exit_d;

  // Search starts one past the previous owner, so that owner is checked last.
  function automatic logic [OW:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] ptr);
    logic [OW:0]   pick;
    logic [OW-1:0] idx;
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      idx = OW'((int'(ptr) + k) % N);
      if (r[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = data_in[i*WIDTH +: WIDTH];
  end

  always_comb begin
    {win_vld_d, win_idx_d} = rr_pick(req, last_q);
    arb_ok_d     = en && win_vld_d;
    drive_exit_d = !req[owner_q] || (burst_cnt_q == BURST_LAST) || !en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      last_q      <= LAST_RST;
      burst_cnt_q <= '0;
      turn_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_ok_d) begin
            state_q     <= DRIVE;
            gnt_q       <= N'(1) << win_idx_d;
            owner_q     <= win_idx_d;
            last_q      <= win_idx_d;
            burst_cnt_q <= '0;
          end
        end
        DRIVE: begin
          burst_cnt_q <= burst_cnt_q + BW'(1);
          if (drive_exit_d) begin
            state_q    <= TURN;
            gnt_q      <= '0;
            turn_cnt_q <= '0;
          end
        end
        TURN: begin
          if (turn_cnt_q == TURN_LAST) begin
            if (arb_ok_d) begin
              state_q     <= DRIVE;
              gnt_q       <= N'(1) << win_idx_d;
              owner_q     <= win_idx_d;
              last_q      <= win_idx_d;
              burst_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            turn_cnt_q <= turn_cnt_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Output enable reacts to en without waiting for the FSM to leave DRIVE.
  assign bus_oe = (state_q == DRIVE) && en;
  assign bus    = bus_oe ? ch_data[owner_q] : {WIDTH{1'bz}};
  assign xfer   = bus_oe && req[owner_q];
  assign gnt    = gnt_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: reset, single requester, round-robin,
// early release, enable gating and reset during a burst.
module tb_tristate_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  wire  [7:0]  bus_w;
  logic        bus_oe;
  logic        xfer;

  int errors;
  int checks;
  int xfer_cnt;
  logic cnt_en;

  logic [7:0] dat [4];

  tristate_bus_arbiter #(
    .WIDTH(8), .N(4), .MAX_BURST(4), .TURN_CYCLES(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .data_in(data_in),
    .gnt    (gnt),
    .owner  (owner),
    .bus    (bus_w),
    .bus_oe (bus_oe),
    .xfer   (xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en && xfer) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // An undriven bus reads as z in a 4-state simulator and as 0 in a 2-state one;
  // channel data is always nonzero, so either reading means nobody drives.
  function automatic logic bus_is_z(input logic [7:0] b);
    return (b === 8'bzzzzzzzz) || (b === 8'h00);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    int o;
    errors   = 0;
    checks   = 0;
    xfer_cnt = 0;
    cnt_en   = 1'b0;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
    data_in = {dat[3], dat[2], dat[1], dat[0]};
    en  = 1'b1;
    rst = 1'b1;
    req = 4'b1111;

    // Reset held two cycles with all channels requesting
    cyc();
    cyc();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_owner", owner, 2'd0);
    check("rst_oe", bus_oe, 1'b0);
    check("rst_xfer", xfer, 1'b0);
    check("rst_bus_z", bus_is_z(bus_w), 1'b1);

    // Round-robin with constant requests: 4 drive cycles, 1 z cycle, owners 0,1,2,3,0
    rst = 1'b0;
    cyc();
    for (int c = 0; c < 21; c++) begin
      p = c % 5;
      o = (c / 5) % 4;
      if (p < 4) begin
        check("rr_gnt", gnt, 32'(4'b0001 << o));
        check("rr_owner", owner, o);
        check("rr_bus", bus_w, dat[o]);
        check("rr_xfer", xfer, 1'b1);
      end else begin
        check("rr_turn_gnt", gnt, 4'b0000);
        check("rr_turn_oe", bus_oe, 1'b0);
        check("rr_turn_bus_z", bus_is_z(bus_w), 1'b1);
      end
      check("rr_onehot", $countones(gnt) <= 1, 1'b1);
      cyc();
    end

    // Single requester on channel 2 held for 10 cycles: 4 drive, 1 z, regrant
    rst = 1'b1;
    req = 4'b0100;
    cyc();
    rst = 1'b0;
    cyc();
    for (int c = 0; c < 10; c++) begin
      p = c % 5;
      if (p < 4) begin
        check("single_gnt", gnt, 4'b0100);
        check("single_bus", bus_w, 8'hA5);
      end else begin
        check("single_turn_gnt", gnt, 4'b0000);
        check("single_turn_bus_z", bus_is_z(bus_w), 1'b1);
      end
      cyc();
    end

    // Early release: channel 1 requests for 2 granted cycles then drops
    rst = 1'b1;
    req = 4'b0010;
    cyc();
    rst = 1'b0;
    xfer_cnt = 0;
    cnt_en = 1'b1;
    cyc();
    check("early_gnt0", gnt, 4'b0010);
    check("early_xfer0", xfer, 1'b1);
    cyc();
    check("early_gnt1", gnt, 4'b0010);
    check("early_xfer1", xfer, 1'b1);
    cyc();
    req = 4'b0000;
    #1;
    check("early_gnt2", gnt, 4'b0010);
    check("early_xfer2", xfer, 1'b0);
    cyc();
    check("early_turn_gnt", gnt, 4'b0000);
    check("early_turn_bus_z", bus_is_z(bus_w), 1'b1);
    cyc();
    check("early_idle_gnt", gnt, 4'b0000);
    cnt_en = 1'b0;
    check("early_words", xfer_cnt, 2);

    // Enable gating: en drops mid-drive, no grants while low
    rst = 1'b1;
    req = 4'b1111;
    cyc();
    rst = 1'b0;
    cyc();
    check("en_gnt0", gnt, 4'b0001);
    check("en_bus0", bus_w, 8'h11);
    cyc();
    en = 1'b0;
    #1;
    check("en_off_oe", bus_oe, 1'b0);
    check("en_off_xfer", xfer, 1'b0);
    check("en_off_bus_z", bus_is_z(bus_w), 1'b1);
    check("en_off_gnt_held", gnt, 4'b0001);
    cyc();
    check("en_turn_gnt", gnt, 4'b0000);
    cyc();
    check("en_idle_gnt_a", gnt, 4'b0000);
    cyc();
    check("en_idle_gnt_b", gnt, 4'b0000);
    check("en_idle_oe", bus_oe, 1'b0);
    en = 1'b1;
    cyc();
    check("en_back_gnt", gnt, 4'b0010);
    check("en_back_owner", owner, 2'd1);
    check("en_back_bus", bus_w, 8'h22);

    // Reset during channel 3's burst
    rst = 1'b1;
    req = 4'b1000;
    cyc();
    rst = 1'b0;
    cyc();
    check("mid_gnt", gnt, 4'b1000);
    check("mid_bus", bus_w, 8'h44);
    rst = 1'b1;
    req = 4'b1111;
    cyc();
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_oe", bus_oe, 1'b0);
    check("mid_rst_bus_z", bus_is_z(bus_w), 1'b1);
    rst = 1'b0;
    cyc();
    check("mid_after_gnt", gnt, 4'b0001);
    check("mid_after_owner", owner, 2'd0);
    check("mid_after_bus", bus_w, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
